// File: rtl/ddr_pkg.sv
// rtl/ddr_pkg.sv - shared types and constants for the chart, arrow and ROM blocks
package ddr_pkg;

  // Defaults shared by the chart ROM, sequencer and arrow datapath
  localparam int DEF_LANES           = 4;
  localparam int DEF_FRAMES_PER_BEAT = 15;

  // Chart entry layout: lane mask in the low bits, end marker just above it
  localparam int MASK_LSB = 0;

  function automatic int end_bit(input int lanes);
    return lanes;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_ISSUE = 3'd4,
    ST_DONE  = 3'd5
  } seq_state_e;

endpackage

// File: rtl/chart_sequencer_if.sv
// rtl/chart_sequencer_if.sv - chart ROM read port and launch bus of the sequencer
interface chart_sequencer_if
  import ddr_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LANES  = DEF_LANES
);

  logic [ADDR_W-1:0] chart_addr;
  logic [LANES:0]    chart_data;
  logic              launch;
  logic [LANES-1:0]  lane;
  logic              beat;

  modport master (
    output chart_addr,
    input  chart_data,
    output launch,
    output lane,
    output beat
  );

  modport slave (
    input  chart_addr,
    output chart_data,
    input  launch,
    input  lane,
    input  beat
  );

endinterface

// File: rtl/chart_sequencer_beat_timer.sv
// rtl/chart_sequencer_beat_timer.sv - frame strobe divider producing one tick per beat
module beat_timer #(
  parameter int FRAMES_PER_BEAT = 15
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic en,
  input  logic frame,
  input  logic clr,
  output logic tick
);

  localparam int CW = (FRAMES_PER_BEAT > 1) ? $clog2(FRAMES_PER_BEAT) : 1;
  localparam logic [CW-1:0] TERM = CW'(FRAMES_PER_BEAT - 1);

  logic [CW-1:0] cnt_q;

  // Tick is combinational so the sequencer can leave WAIT on the terminal frame itself
  assign tick = en && frame && (cnt_q == TERM);

  // Count qualifying frames; a gated or paused frame leaves the count untouched
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && frame) begin
      cnt_q <= tick ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/chart_sequencer.sv
// rtl/chart_sequencer.sv - walks the note chart and issues frame-paced arrow launches
module chart_sequencer
  import ddr_pkg::*;
#(
  parameter int CHART_DEPTH     = 256,
  parameter int ADDR_W          = 8,
  parameter int LANES           = DEF_LANES,
  parameter int FRAMES_PER_BEAT = DEF_FRAMES_PER_BEAT
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             frame_i,
  input  logic             start_i,
  input  logic             pause_i,
  chart_sequencer_if.master bus,
  output logic             busy_o,
  output logic             done_o
);

  localparam int END_BIT = end_bit(LANES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CHART_DEPTH - 1);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LANES-1:0]  mask_q;
  logic [LANES-1:0]  lane_q;
  logic              launch_q, beat_q;
  logic              start_ok, tick;

  // A new run may only begin from rest; mid-chart starts are dropped
  assign start_ok = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  beat_timer #(
    .FRAMES_PER_BEAT(FRAMES_PER_BEAT)
  ) u_beat_timer (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .en       ((state_q == ST_WAIT) && !pause_i),
    .frame    (frame_i),
    .clr      (start_ok),
    .tick     (tick)
  );

  // Next-state decode for the chart walk
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD:  state_d = bus.chart_data[END_BIT] ? ST_DONE : ST_WAIT;
      ST_WAIT:  if (tick) state_d = ST_ISSUE;
      ST_ISSUE: state_d = (addr_q == LAST_ADDR) ? ST_DONE : ST_FETCH;
      ST_DONE:  if (start_i) state_d = ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Address, entry capture and the registered launch outputs that mark the ISSUE cycle
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      addr_q   <= '0;
      mask_q   <= '0;
      lane_q   <= '0;
      launch_q <= 1'b0;
      beat_q   <= 1'b0;
    end else begin
      if (start_ok) begin
        addr_q <= '0;
      end else if ((state_q == ST_ISSUE) && (addr_q != LAST_ADDR)) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
      if (state_q == ST_LOAD) begin
        mask_q <= bus.chart_data[MASK_LSB +: LANES];
      end
      beat_q   <= (state_d == ST_ISSUE);
      launch_q <= (state_d == ST_ISSUE) && (mask_q != '0);
      lane_q   <= (state_d == ST_ISSUE) ? mask_q : '0;
    end
  end

  assign bus.chart_addr = addr_q;
  assign bus.launch     = launch_q;
  assign bus.lane       = lane_q;
  assign bus.beat       = beat_q;
  assign busy_o = (state_q == ST_FETCH) || (state_q == ST_LOAD) ||
                  (state_q == ST_WAIT)  || (state_q == ST_ISSUE);
  assign done_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_chart_sequencer.sv
// tb/tb_chart_sequencer.sv - scoreboard bench for chart_sequencer
module tb_chart_sequencer;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int LN    = 4;
  localparam int FPB   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic frame = 1'b0, start = 1'b0, pause = 1'b0;
  logic busy, done;

  chart_sequencer_if #(.ADDR_W(AW), .LANES(LN)) bus ();

  chart_sequencer #(
    .CHART_DEPTH(DEPTH), .ADDR_W(AW), .LANES(LN), .FRAMES_PER_BEAT(FPB)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n), .frame_i(frame), .start_i(start),
    .pause_i(pause), .bus(bus.master), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  logic [LN:0] rom [DEPTH];
  always @(posedge clk) bus.chart_data <= rom[bus.chart_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_done;
    int          at;
    bit          launch;
    logic [LN-1:0] lane;
    int          addr;
  } exp_t;
  exp_t sb[$];

  int checks = 0, passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: progress through the chart in terms of counted frames
  bit m_active = 0;
  int m_idx = 0, m_cnt = 0, m_wait_from = 0, m_done_at = 0;
  bit pv = 0;

  task automatic push_beat(input int at, input int idx);
    exp_t e;
    e.is_done = 0; e.at = at; e.addr = idx;
    e.lane = rom[idx][LN-1:0];
    e.launch = (rom[idx][LN-1:0] != 0);
    sb.push_back(e);
  endtask

  task automatic push_done(input int at, input int idx);
    exp_t e;
    e.is_done = 1; e.at = at; e.addr = idx; e.lane = '0; e.launch = 0;
    sb.push_back(e);
    m_active = 0;
    m_done_at = at;
  endtask

  task automatic step(input bit f, input bit p, input bit s);
    frame = f; pause = p; start = s;
    if (s && !m_active && cyc >= m_done_at) begin
      m_active = 1; m_idx = 0; m_cnt = 0; m_wait_from = cyc + 3;
      if (rom[0][LN]) push_done(cyc + 3, 0);
    end else if (f && !p && m_active && cyc >= m_wait_from) begin
      m_cnt++;
      if (m_cnt == FPB) begin
        m_cnt = 0;
        push_beat(cyc + 1, m_idx);
        if (m_idx == DEPTH - 1) begin
          push_done(cyc + 2, m_idx);
        end else begin
          m_idx++;
          m_wait_from = cyc + 4;
          if (rom[m_idx][LN]) push_done(cyc + 4, m_idx);
        end
      end
    end
    @(posedge clk); #1;
    frame = 0; start = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, pause, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_beat"}, bus.beat, 0);
    chk({tag, "_launch"}, bus.launch, 0);
    chk({tag, "_lane"}, bus.lane, 0);
    chk({tag, "_addr"}, bus.chart_addr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic mid_reset();
    #2 rst_n = 0;
    #1 check_zero("midrst");
    sb.delete();
    m_active = 0; m_cnt = 0; m_done_at = 0;
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1;
    @(posedge clk); #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT shows a beat or enters DONE
  bit prev_done = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.beat) begin
        if (sb.size() == 0) chk("beat_expected", 0, 1);
        else begin
          e = sb.pop_front();
          chk("beat_kind", e.is_done, 0);
          chk("beat_cycle", cyc, e.at);
          chk("launch", bus.launch, e.launch);
          chk("lane", bus.lane, e.lane);
          chk("beat_addr", bus.chart_addr, e.addr);
        end
      end else if (bus.launch || bus.lane != 0) begin
        chk("stray_launch", {bus.launch, bus.lane}, 0);
      end
      if (done && !prev_done) begin
        if (sb.size() == 0) chk("done_expected", 0, 1);
        else begin
          e = sb.pop_front();
          chk("done_kind", e.is_done, 1);
          chk("done_cycle", cyc, e.at);
          chk("done_addr", bus.chart_addr, e.addr);
        end
      end
    end
    prev_done = done;
  end

  initial begin
    int s0, guard;
    bit lst;
    foreach (rom[i]) rom[i] = '0;
    #1 rst_n = 0;
    #1 check_zero("reset");
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1;
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    // Directed chart with a rest beat and an end marker, plus first-launch latency
    rom[0] = 5'h01; rom[1] = 5'h00; rom[2] = 5'h04; rom[3] = 5'h10;
    s0 = cyc;
    step(0, 0, 1);
    idle(4);
    repeat (3) step(1, 0, 0);
    step(0, 0, 0);
    chk("lat_cycle", cyc, s0 + 9);
    chk("lat_addr", bus.chart_addr, 1);
    repeat (8) begin step(1, 0, 0); idle(9); end
    chk("chart_done", done, 1);
    chk("chart_done_addr", bus.chart_addr, 3);

    // Full chart without end marker, pause hold, and ignored starts
    foreach (rom[i]) rom[i] = 5'h02;
    step(0, 0, 1);
    idle(4);
    step(1, 0, 0); idle(3);
    repeat (4) begin step(1, 1, 0); step(0, 1, 0); step(0, 1, 0); end
    chk("pause_addr", bus.chart_addr, 0);
    chk("pause_busy", busy, 1);
    step(1, 0, 0); idle(3);
    step(1, 0, 0);
    step(0, 0, 1);
    idle(2);
    step(0, 0, 1);
    for (int b = 0; b < 7; b++) begin
      for (int k = 0; k < 3; k++) begin
        lst = (b == 6 && k == 2);
        step(1, 0, 0); step(0, 0, !lst); step(0, 0, 0); step(0, 0, !lst); step(0, 0, 0);
      end
    end
    chk("full_done", done, 1);
    chk("full_addr", bus.chart_addr, DEPTH - 1);
    step(0, 0, 1);
    chk("restart_addr", bus.chart_addr, 0);
    chk("restart_busy", busy, 1);
    idle(3);

    // Reach address 5 with two frames counted, then reset mid-WAIT
    repeat (17) begin step(1, 0, 0); idle(4); end
    chk("prerst_addr", bus.chart_addr, 5);
    mid_reset();
    step(0, 0, 1);
    chk("postrst_addr", bus.chart_addr, 0);
    idle(3);
    repeat (3) begin step(1, 0, 0); idle(4); end

    // Randomized charts, frames, pauses and starts
    for (int c = 0; c < 8; c++) begin
      guard = 0;
      while ((m_active || cyc < m_done_at) && guard < 3000) begin
        step($urandom % 2 == 0, 0, 0);
        guard++;
      end
      chk("drain_bound", int'(guard < 3000), 1);
      foreach (rom[i]) begin
        rom[i][LN-1:0] = LN'($urandom);
        rom[i][LN] = ($urandom % 10 == 0);
      end
      step(0, 0, 1);
      repeat (300) begin
        if ($urandom % 8 == 0) pv = !pv;
        step($urandom % 3 == 0, pv, $urandom % 20 == 0);
      end
    end
    pause = 0;
    guard = 0;
    while ((m_active || cyc < m_done_at) && guard < 3000) begin
      step($urandom % 2 == 0, 0, 0);
      guard++;
    end
    idle(10);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
